// File: rtl/paddle_tracker.sv
// Per-frame vertical bounding box of the left and right paddles.
// Publishes the centre row, height and found flag of each paddle, registered and held for a frame.
module paddle_tracker #(
   parameter int unsigned MIN_PIXELS = 64,
   parameter int unsigned CNT_W      = 17,
   parameter int unsigned DEFAULT_Y  = 240
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_i,
   input  logic        vs_ni,
   input  logic        blank_ni,
   input  logic [12:0] row,
   input  logic [12:0] col,
   input  logic        left_paddle,
   input  logic        right_paddle,
   output logic [12:0] left_y,
   output logic [12:0] right_y,
   output logic [12:0] left_h,
   output logic [12:0] right_h,
   output logic        left_found,
   output logic        right_found,
   output logic        frame_valid
);

   localparam int unsigned RW    = 13;
   localparam int unsigned NSIDE = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);
   localparam logic [RW-1:0]    Y_RST   = RW'(DEFAULT_Y);

   // Side index 0 = left paddle, 1 = right paddle.
   logic [NSIDE-1:0] flag_c;
   logic             fe_c;

   logic             vs_prev_q, vs_prev_d;
   logic             fv_q, fv_d;
   logic [RW-1:0]    min_q   [NSIDE];
   logic [RW-1:0]    min_d   [NSIDE];
   logic [RW-1:0]    max_q   [NSIDE];
   logic [RW-1:0]    max_d   [NSIDE];
   logic [CNT_W-1:0] cnt_q   [NSIDE];
   logic [CNT_W-1:0] cnt_d   [NSIDE];
   logic [RW-1:0]    y_q     [NSIDE];
   logic [RW-1:0]    y_d     [NSIDE];
   logic [RW-1:0]    h_q     [NSIDE];
   logic [RW-1:0]    h_d     [NSIDE];
   logic [NSIDE-1:0] found_q, found_d;
   logic [RW:0]      sum_c   [NSIDE];
   logic [NSIDE-1:0] qual_c;

   // Column is carried for debug only and does not feed the reduction.
   logic unused_col;
   assign unused_col = ^col;

   assign flag_c = {right_paddle, left_paddle};

   // Frame-end detection, accumulator update and result capture.
   always_comb begin
      fe_c      = en_i & vs_prev_q & ~vs_ni;
      vs_prev_d = en_i ? vs_ni : vs_prev_q;
      fv_d      = fe_c;
      found_d   = found_q;
      qual_c    = '0;
      for (int s = 0; s < int'(NSIDE); s++) begin
         qual_c[s] = en_i & blank_ni & flag_c[s];
         sum_c[s]  = {1'b0, min_q[s]} + {1'b0, max_q[s]};
         min_d[s]  = fe_c ? '1 : min_q[s];
         max_d[s]  = fe_c ? '0 : max_q[s];
         cnt_d[s]  = fe_c ? '0 : cnt_q[s];
         y_d[s]    = y_q[s];
         h_d[s]    = h_q[s];

         // The frame-end pixel seeds the new frame after the restart above.
         if (qual_c[s]) begin
            if (row < min_d[s]) min_d[s] = row;
            if (row > max_d[s]) max_d[s] = row;
            if (cnt_d[s] != CNT_MAX) cnt_d[s] = cnt_d[s] + CNT_W'(1);
         end

         if (fe_c) begin
            if (cnt_q[s] >= CNT_MIN) begin
               y_d[s]     = sum_c[s][RW:1];
               h_d[s]     = max_q[s] - min_q[s] + RW'(1);
               found_d[s] = 1'b1;
            end else begin
               h_d[s]     = '0;
               found_d[s] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_prev_q <= 1'b1;
         fv_q      <= 1'b0;
         found_q   <= '0;
         for (int s = 0; s < int'(NSIDE); s++) begin
            min_q[s] <= '1;
            max_q[s] <= '0;
            cnt_q[s] <= '0;
            y_q[s]   <= Y_RST;
            h_q[s]   <= '0;
         end
      end else begin
         vs_prev_q <= vs_prev_d;
         fv_q      <= fv_d;
         found_q   <= found_d;
         for (int s = 0; s < int'(NSIDE); s++) begin
            min_q[s] <= min_d[s];
            max_q[s] <= max_d[s];
            cnt_q[s] <= cnt_d[s];
            y_q[s]   <= y_d[s];
            h_q[s]   <= h_d[s];
         end
      end
   end

   assign left_y      = y_q[0];
   assign right_y     = y_q[1];
   assign left_h      = h_q[0];
   assign right_h     = h_q[1];
   assign left_found  = found_q[0];
   assign right_found = found_q[1];
   assign frame_valid = fv_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker; a second instance with a 3-bit counter
// exercises counter saturation on the same pixel stream.
module tb_paddle_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_i, vs_ni, blank_ni, left_paddle, right_paddle;
   logic [12:0] row, col;

   logic [12:0] left_y, right_y, left_h, right_h;
   logic        left_found, right_found, frame_valid;
   logic [12:0] s_left_y, s_right_y, s_left_h, s_right_h;
   logic        s_left_found, s_right_found, s_frame_valid;

   int errors = 0;
   int checks = 0;

   paddle_tracker dut (
      .clk(clk), .reset(reset), .en_i(en_i), .vs_ni(vs_ni), .blank_ni(blank_ni),
      .row(row), .col(col), .left_paddle(left_paddle), .right_paddle(right_paddle),
      .left_y(left_y), .right_y(right_y), .left_h(left_h), .right_h(right_h),
      .left_found(left_found), .right_found(right_found), .frame_valid(frame_valid)
   );

   paddle_tracker #(.MIN_PIXELS(7), .CNT_W(3), .DEFAULT_Y(240)) dut_sat (
      .clk(clk), .reset(reset), .en_i(en_i), .vs_ni(vs_ni), .blank_ni(blank_ni),
      .row(row), .col(col), .left_paddle(left_paddle), .right_paddle(right_paddle),
      .left_y(s_left_y), .right_y(s_right_y), .left_h(s_left_h), .right_h(s_right_h),
      .left_found(s_left_found), .right_found(s_right_found), .frame_valid(s_frame_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic vs, input logic blank,
                        input logic l, input logic r, input int rw, input int cl);
      en_i = en; vs_ni = vs; blank_ni = blank; left_paddle = l; right_paddle = r;
      row = 13'(rw); col = 13'(cl);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic fe();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      en_i = 1'b1; vs_ni = 1'b1; blank_ni = 1'b0; left_paddle = 1'b0; right_paddle = 1'b0;
      row = '0; col = '0;
      #12;
      chk("rst_left_y", 32'(left_y), 240);
      chk("rst_right_y", 32'(right_y), 240);
      chk("rst_h", 32'({left_h, right_h}), 0);
      chk("rst_found", 32'({left_found, right_found}), 0);
      chk("rst_fv", 32'(frame_valid), 0);
      @(negedge clk);
      reset = 1'b0;

      // 1: empty frame
      repeat (3) idle();
      chk("t1_fv_idle", 32'(frame_valid), 0);
      fe();
      chk("t1_fv", 32'(frame_valid), 1);
      chk("t1_y", 32'({left_y, right_y}), 32'({13'd240, 13'd240}));
      chk("t1_h", 32'({left_h, right_h}), 0);
      chk("t1_found", 32'({left_found, right_found}), 0);
      fe();
      chk("t1_fv_hold_low", 32'(frame_valid), 0);
      repeat (3) fe();
      chk("t1_fv_single", 32'(frame_valid), 0);
      idle();

      // 2: left paddle 400 px rows 100..139
      for (int r = 100; r <= 139; r++)
         for (int c = 20; c <= 29; c++)
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, r, c);
      chk("t2_fv_before", 32'(frame_valid), 0);
      fe();
      chk("t2_fv", 32'(frame_valid), 1);
      chk("t2_left_y", 32'(left_y), 119);
      chk("t2_left_h", 32'(left_h), 40);
      chk("t2_left_found", 32'(left_found), 1);
      chk("t2_right_found", 32'(right_found), 0);
      chk("t2_right_y", 32'(right_y), 240);
      chk("t2_sat_left_found", 32'(s_left_found), 1);
      idle();
      chk("t2_fv_off", 32'(frame_valid), 0);
      chk("t2_left_y_stable", 32'(left_y), 119);

      // 3: right paddle at 300, then a 30 px frame
      for (int r = 280; r <= 320; r++)
         for (int c = 600; c <= 601; c++)
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, r, c);
      fe();
      chk("t3a_right_y", 32'(right_y), 300);
      chk("t3a_right_h", 32'(right_h), 41);
      chk("t3a_right_found", 32'(right_found), 1);
      chk("t3a_left_found", 32'(left_found), 0);
      chk("t3a_left_h", 32'(left_h), 0);
      chk("t3a_left_y_hold", 32'(left_y), 119);
      idle();
      for (int c = 0; c < 30; c++)
         drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10, c);
      fe();
      chk("t3b_right_y", 32'(right_y), 300);
      chk("t3b_right_h", 32'(right_h), 0);
      chk("t3b_right_found", 32'(right_found), 0);
      chk("t3b_sat_right_found", 32'(s_right_found), 1);
      chk("t3b_sat_right_y", 32'(s_right_y), 10);
      chk("t3b_sat_right_h", 32'(s_right_h), 1);
      idle();

      // 4: flags during blanking or with en_i low are ignored
      for (int r = 0; r < 480; r++)
         drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, r, 5);
      for (int r = 0; r < 480; r++)
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, r, 5);
      chk("t4_fv_en_low", 32'(frame_valid), 0);
      idle();
      chk("t4_fv_no_edge", 32'(frame_valid), 0);

      // 5: frame end carries a row-5 pixel into the next frame
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5, 7);
      chk("t4_fv", 32'(frame_valid), 1);
      chk("t4_found", 32'({left_found, right_found}), 0);
      chk("t4_h", 32'({left_h, right_h}), 0);
      chk("t4_y_hold", 32'({left_y, right_y}), 32'({13'd119, 13'd300}));
      idle();
      for (int r = 200; r <= 209; r++)
         for (int c = 40; c < 50; c++)
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, r, c);
      fe();
      chk("t5_left_y", 32'(left_y), 107);
      chk("t5_left_h", 32'(left_h), 205);
      chk("t5_left_found", 32'(left_found), 1);
      idle();

      // 6: reset mid-frame discards partial accumulation
      for (int r = 60; r < 110; r++)
         for (int c = 0; c < 10; c++)
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, r, c);
      reset = 1'b1;
      #2;
      chk("t6_async_y", 32'(left_y), 240);
      chk("t6_async_found", 32'(left_found), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 10; c++)
         drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 50, c);
      fe();
      chk("t6_fv", 32'(frame_valid), 1);
      chk("t6_left_found", 32'(left_found), 0);
      chk("t6_left_h", 32'(left_h), 0);
      chk("t6_left_y", 32'(left_y), 240);
      idle();
      chk("t6_fv_off", 32'(frame_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
